mp_job_dispatch: RTL and testbench

MP_JOB_DISPATCH -- requirements
Module: mp_job_dispatch

---
 rtl/mp_pkg.sv | 18 +
 rtl/mp_info_fifo.sv | 60 ++++++
 rtl/mp_job_dispatch.sv | 107 ++++++++++
 tb/tb_mp_job_dispatch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared job-word layout, FSM encoding and descriptor stride for the job dispatcher
// and the upstream control block.
package mp_pkg;
  localparam int unsigned ADDR_LSB       = 0;
  localparam int unsigned ADDR_W         = 64;
  localparam int unsigned PASID_LSB      = 64;
  localparam int unsigned CNT_LSB        = 73;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned INFO_USED_W    = CNT_LSB + CNT_W;
  localparam int unsigned DESC_BYTES_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } mp_state_e;
endpackage

// File: rtl/mp_info_fifo.sv
// Synchronous job FIFO with registered occupancy level and registered ready flag.
module mp_info_fifo #(
  parameter int unsigned WIDTH = 81,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;

  assign w_push  = i_push && r_ready;
  assign w_pop   = i_pop && (r_level != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_ready = r_ready;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop)
      w_level_nxt = r_level - LW'(1);
  end

  // Ready follows the post-update level, so a pop while full frees space only next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt < LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/mp_job_dispatch.sv
// Job dispatcher: queues process-info words and turns each job into a run of
// descriptor fetch requests, then waits for downstream completion.
module mp_job_dispatch
  import mp_pkg::*;
#(
  parameter int unsigned PINFO_WIDTH = 88,
  parameter int unsigned PASID_WIDTH = 9,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DESC_BYTES  = DESC_BYTES_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [PINFO_WIDTH-1:0]        process_info_i,
  input  logic                          process_start_i,
  output logic                          process_ready_o,
  output logic                          desc_req_valid_o,
  input  logic                          desc_req_ready_i,
  output logic [63:0]                   desc_req_addr_o,
  output logic [PASID_WIDTH-1:0]        desc_req_pasid_o,
  output logic                          desc_req_last_o,
  input  logic                          job_done_i,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level_o,
  output logic                          busy_o,
  output logic [15:0]                   dropped_cnt_o
);
  localparam int unsigned JOB_W = ADDR_W + PASID_WIDTH + CNT_W;

  mp_state_e              r_state;
  mp_state_e              w_state_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic [PASID_WIDTH-1:0] r_pasid;
  logic [CNT_W-1:0]       r_remaining;
  logic [15:0]            r_dropped;
  logic                   w_pop;
  logic [JOB_W-1:0]       w_push_data;
  logic [JOB_W-1:0]       w_head;
  logic [ADDR_W-1:0]      w_head_addr;
  logic [PASID_WIDTH-1:0] w_head_pasid;
  logic [CNT_W-1:0]       w_head_cnt;
  logic                   w_unused_info;

  // Only the used fields are queued; the reserved top bits are dropped here.
  assign w_push_data = {process_info_i[CNT_LSB +: CNT_W],
                        process_info_i[PASID_LSB +: PASID_WIDTH],
                        process_info_i[ADDR_LSB +: ADDR_W]};
  assign w_unused_info = ^process_info_i[PINFO_WIDTH-1:INFO_USED_W];
  assign {w_head_cnt, w_head_pasid, w_head_addr} = w_head;

  mp_info_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_info_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (process_start_i),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (queue_level_o),
    .o_ready (process_ready_o)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE:      if (queue_level_o != '0) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_pop       = 1'b1;
        w_state_nxt = (w_head_cnt != '0) ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE:     if (desc_req_ready_i && (r_remaining == CNT_W'(1))) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (job_done_i) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_pasid     <= '0;
      r_remaining <= '0;
      r_dropped   <= '0;
    end else if (r_state == ST_LOAD) begin
      r_addr      <= w_head_addr;
      r_pasid     <= w_head_pasid;
      r_remaining <= w_head_cnt;
      if ((w_head_cnt == '0) && (r_dropped != '1))
        r_dropped <= r_dropped + 16'd1;
    end else if ((r_state == ST_ISSUE) && desc_req_ready_i) begin
      r_addr      <= r_addr + 64'(DESC_BYTES);
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  assign desc_req_valid_o = (r_state == ST_ISSUE);
  assign desc_req_addr_o  = r_addr;
  assign desc_req_pasid_o = r_pasid;
  assign desc_req_last_o  = (r_remaining == CNT_W'(1));
  assign busy_o           = (r_state != ST_IDLE);
  assign dropped_cnt_o    = r_dropped;
endmodule

// File: tb/tb_mp_job_dispatch.sv
// Bench for mp_job_dispatch: queue-based job model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mp_job_dispatch;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [87:0] info = '0;
  logic        start = 1'b0;
  logic        req_rdy = 1'b0;
  logic        done = 1'b0;
  logic        process_ready_o, desc_req_valid_o, desc_req_last_o, busy_o;
  logic [63:0] desc_req_addr_o;
  logic [8:0]  desc_req_pasid_o;
  logic [3:0]  queue_level_o;
  logic [15:0] dropped_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  mp_job_dispatch #(
    .PINFO_WIDTH (88),
    .PASID_WIDTH (9),
    .FIFO_DEPTH  (8),
    .DESC_BYTES  (128)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .process_info_i   (info),
    .process_start_i  (start),
    .process_ready_o  (process_ready_o),
    .desc_req_valid_o (desc_req_valid_o),
    .desc_req_ready_i (req_rdy),
    .desc_req_addr_o  (desc_req_addr_o),
    .desc_req_pasid_o (desc_req_pasid_o),
    .desc_req_last_o  (desc_req_last_o),
    .job_done_i       (done),
    .queue_level_o    (queue_level_o),
    .busy_o           (busy_o),
    .dropped_cnt_o    (dropped_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a job queue plus the current job's phase
  // (0 idle, 1 load, 2 issuing, 3 awaiting completion).
  typedef struct packed {
    logic [63:0] a;
    logic [8:0]  p;
    logic [7:0]  c;
  } job_t;
  job_t        q[$];
  int          m_ph = 0;
  logic [63:0] m_addr = '0;
  logic [8:0]  m_pasid = '0;
  int          m_rem = 0;
  int          m_drop = 0;
  bit          m_ready = 1'b1;
  bit          m_acc = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_ph = 0; m_addr = '0; m_pasid = '0; m_rem = 0; m_drop = 0;
      m_ready = 1'b1; m_acc = 1'b0;
    end else begin
      job_t j;
      m_acc = start && m_ready;
      case (m_ph)
        0: if (q.size() != 0) m_ph = 1;
        1: begin
          j = q.pop_front();
          m_addr = j.a; m_pasid = j.p; m_rem = int'(j.c);
          if (j.c == 0) begin
            if (m_drop < 65535) m_drop++;
            m_ph = 0;
          end else m_ph = 2;
        end
        2: if (req_rdy) begin
          m_addr = m_addr + 64'd128;
          m_rem--;
          if (m_rem == 0) m_ph = 3;
        end
        default: if (done) m_ph = 0;
      endcase
      if (m_acc) begin
        j.a = info[63:0]; j.p = info[72:64]; j.c = info[80:73];
        q.push_back(j);
      end
      m_ready = (q.size() < 8);
    end
  end

  always @(negedge clk) begin
    chk("ready", process_ready_o, m_ready);
    chk("valid", desc_req_valid_o, m_ph == 2);
    chk("level", queue_level_o, q.size());
    chk("busy", busy_o, m_ph != 0);
    chk("dropped", dropped_cnt_o, m_drop);
    if (m_ph == 2) begin
      chk("addr", desc_req_addr_o, m_addr);
      chk("pasid", desc_req_pasid_o, m_pasid);
      chk("last", desc_req_last_o, m_rem == 1);
    end
  end

  task automatic push_job(input logic [63:0] a, input logic [8:0] p, input logic [7:0] c,
                          input int maxw, output bit ok);
    start = 1'b1;
    info  = {7'($urandom), c, p, a};
    ok    = 1'b0;
    for (int k = 0; k < maxw; k++) begin
      @(negedge clk);
      if (m_acc) begin ok = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  task automatic wait_valid(input int maxw, output int n);
    n = 0;
    while (!desc_req_valid_o && n < maxw) begin @(negedge clk); n++; end
  endtask

  task automatic drain();
    req_rdy = 1'b1; done = 1'b1;
    for (int k = 0; k < 300 && (q.size() != 0 || m_ph != 0); k++) @(negedge clk);
    chk("drained", busy_o, 1'b0);
    req_rdy = 1'b0; done = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    int lat;
    logic [63:0] exp_a [3];

    repeat (3) @(negedge clk);
    chk("rst_ready", process_ready_o, 1'b1);
    chk("rst_valid", desc_req_valid_o, 1'b0);
    chk("rst_level", queue_level_o, 0);
    resetn = 1'b1;
    @(negedge clk);

    // basic job: three requests at 128-byte stride
    req_rdy = 1'b1;
    push_job(64'h1000, 9'd5, 8'd3, 10, ok);
    chk("push1_acc", ok, 1'b1);
    lat = 1;
    while (!desc_req_valid_o && lat < 10) begin @(negedge clk); lat++; end
    chk("latency", lat, 3);
    exp_a[0] = 64'h1000; exp_a[1] = 64'h1080; exp_a[2] = 64'h1100;
    for (int i = 0; i < 3; i++) begin
      chk("j1_valid", desc_req_valid_o, 1'b1);
      chk("j1_addr", desc_req_addr_o, exp_a[i]);
      chk("j1_pasid", desc_req_pasid_o, 9'd5);
      chk("j1_last", desc_req_last_o, i == 2);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      chk("j1_wait_busy", busy_o, 1'b1);
      chk("j1_wait_valid", desc_req_valid_o, 1'b0);
      @(negedge clk);
    end
    done = 1'b1; @(negedge clk); done = 1'b0;
    chk("j1_idle", busy_o, 1'b0);

    // completion pulse while idle is ignored
    done = 1'b1; @(negedge clk); done = 1'b0;
    chk("idle_done_busy", busy_o, 1'b0);
    chk("idle_done_drop", dropped_cnt_o, 16'd0);
    @(negedge clk);
    chk("idle_done_busy2", busy_o, 1'b0);

    // zero-count job is dropped
    push_job(64'h2000, 9'd7, 8'd0, 10, ok);
    n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (desc_req_valid_o) n++;
    end
    chk("drop_idle", busy_o, 1'b0);
    chk("drop_cnt", dropped_cnt_o, 16'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (desc_req_valid_o) n++;
    end
    chk("drop_novalid", n, 0);

    // address wraps modulo 2^64
    push_job(64'hFFFF_FFFF_FFFF_FF80, 9'h1FF, 8'd2, 10, ok);
    wait_valid(10, n);
    chk("wrap_a0", desc_req_addr_o, 64'hFFFF_FFFF_FFFF_FF80);
    chk("wrap_l0", desc_req_last_o, 1'b0);
    @(negedge clk);
    chk("wrap_a1", desc_req_addr_o, 64'h0);
    chk("wrap_l1", desc_req_last_o, 1'b1);
    @(negedge clk);
    done = 1'b1; @(negedge clk); done = 1'b0;

    // fill the queue behind a stalled job
    req_rdy = 1'b0;
    push_job(64'h3000, 9'd3, 8'd1, 10, ok);
    wait_valid(10, n);
    chk("full_first_valid", desc_req_valid_o, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push_job(64'h4000 + 64'(i) * 64'h100, 9'(i), 8'd1, 10, ok);
      chk("full_push_acc", ok, 1'b1);
    end
    chk("full_level", queue_level_o, 8);
    chk("full_ready", process_ready_o, 1'b0);
    start = 1'b1;
    info  = {7'h55, 8'd1, 9'd9, 64'h9000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_blocked", process_ready_o, 1'b0);
      chk("full_hold", queue_level_o, 8);
    end
    req_rdy = 1'b1; @(negedge clk); req_rdy = 1'b0;
    done = 1'b1; @(negedge clk); done = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_acc) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    chk("ninth_acc", ok, 1'b1);
    chk("ninth_level", queue_level_o, 8);
    drain();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_rdy = ($urandom_range(3) != 0);
      done    = ($urandom_range(4) == 0);
      if (!start || m_acc) begin
        start = ($urandom_range(2) != 0);
        info  = {7'($urandom), 8'($urandom_range(4)), 9'($urandom),
                 ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(255))
                                         : {32'($urandom), 32'($urandom)}};
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // reset in the middle of an issuing job
    push_job(64'h5000, 9'd2, 8'd4, 10, ok);
    wait_valid(10, n);
    chk("pre_rst_valid", desc_req_valid_o, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", desc_req_valid_o, 1'b0);
    chk("mid_rst_level", queue_level_o, 0);
    chk("mid_rst_ready", process_ready_o, 1'b1);
    chk("mid_rst_busy", busy_o, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
